dma_priority_arbiter: RTL and testbench
=======================================

DMA_PRIORITY_ARBITER -- requirements
Module: dma_priority_arbiter

Interface
REQ-001 Parameter: REQ_SYNC, default 1, DREQ register stages (0 or 1) before arbitration.
REQ-002 Clock  input  1  system clock; all state updates on rising edge.
REQ-003 nReset  input  1  asynchronous, active-low reset.
REQ-004 MasterClear  input  1  synchronous clear pulse, same effect as reset.
REQ-005 DREQ  input  4  hardware channel requests, polarity per CmdReg[6].
REQ-006 ReqReg  input  4  software request bits, active-high.
REQ-007 MaskReg  input  4  channel mask bits; 1 = masked.
REQ-008 CmdReg  input  8  command register: bit2 controller disable, bit4 rotating priority, bit6 DREQ active-low, bit7 DACK active-high.
REQ-009 HLDA  input  1  hold acknowledge from the CPU.
REQ-010 SvcDone  input  1  one-cycle pulse from the timing engine when service ends (EOP, count done or demand dropped).
REQ-011 HRQ  output  1  hold request to the CPU, registered.
REQ-012 DACK  output  4  per-channel acknowledge, polarity per CmdReg[7].
REQ-013 GrantValid  output  1  high while a channel owns the bus.
REQ-014 GrantChan  output  2  index of the granted channel; held while GrantValid=1.
REQ-015 ReqStatus  output  4  effective pending requests, for status register bits 7:4.

Function
REQ-016 Hardware request for channel i: DREQ[i] XOR CmdReg[6], after REQ_SYNC stages.
REQ-017 Effective request: (hardware request AND NOT MaskReg[i]) OR ReqReg[i]; software requests ignore the mask.
REQ-018 ReqStatus shall equal the effective request vector, registered.
REQ-019 FSM states: IDLE, WAIT_HLDA, GRANT, RELEASE.
REQ-020 IDLE -> WAIT_HLDA when any effective request is set and CmdReg[2]=0; HRQ=1 from the same edge.
REQ-021 WAIT_HLDA -> IDLE, HRQ=0, if all effective requests clear before HLDA=1.
REQ-022 WAIT_HLDA -> GRANT on the first edge with HLDA=1; the winner is chosen from requests sampled at that edge.
REQ-023 Entering GRANT: GrantChan latched, GrantValid=1, selected DACK active, all other DACK inactive.
REQ-024 GRANT holds until SvcDone=1; requests, mask and disable changes in GRANT shall not preempt or change GrantChan.
REQ-025 GRANT -> RELEASE on SvcDone: GrantValid=0, DACK all inactive, HRQ=0 on the same edge.
REQ-026 RELEASE -> IDLE when HLDA=0; no new HRQ while HLDA=1.
REQ-027 Fixed priority (CmdReg[4]=0): channel 0 highest, channel 3 lowest.
REQ-028 Rotating priority (CmdReg[4]=1): 2-bit pointer marks the highest-priority channel, with order pointer, pointer+1, ... mod 4.
REQ-029 On SvcDone in rotating mode, pointer := GrantChan+1 mod 4 (wraps 3 -> 0); in fixed mode the pointer is unchanged.
REQ-030 HLDA dropping during GRANT is a protocol error: go to IDLE, GrantValid=0, DACK inactive, HRQ=0, pointer unchanged.
REQ-031 DACK output = grant one-hot XOR {4{~CmdReg[7]}}; polarity changes apply combinationally.
REQ-032 SvcDone outside GRANT shall be ignored.

Reset
REQ-033 nReset=0 or MasterClear=1 shall force: state IDLE, HRQ=0, GrantValid=0, GrantChan=0, ReqStatus=0, pointer=0, DREQ sync flops cleared.
REQ-034 The DACK inactive level at reset follows CmdReg[7]: 4'hF when CmdReg=8'h00.
REQ-035 Reset asserted mid-GRANT shall drop HRQ, GrantValid and DACK immediately (asynchronously), without waiting for SvcDone.

Verification
REQ-036 Reset: nReset=0 with CmdReg=8'h00 -> HRQ=0, GrantValid=0, DACK=4'hF, ReqStatus=0; after release with no requests, outputs stay the same.
REQ-037 Fixed priority: CmdReg=8'h00, DREQ=4'b0110, HLDA raised 3 cycles after HRQ -> GrantChan=1, DACK=4'b1101; SvcDone with DREQ2 held -> RELEASE, HLDA low, then HRQ again, GrantChan=2.
REQ-038 Rotating priority: CmdReg=8'h10, DREQ=4'hF held, HLDA follows HRQ -> grant order 0,1,2,3,0 across five SvcDone pulses.
REQ-039 Mask and software request: MaskReg=4'hF, DREQ=4'hF -> HRQ stays 0, ReqStatus=0; then ReqReg=4'b0100 -> HRQ=1, GrantChan=2.
REQ-040 Polarity: CmdReg=8'hC0, DREQ=4'b1110 -> grant channel 0, DACK=4'b0001; CmdReg[2]=1 in IDLE with a pending request -> HRQ stays 0.
REQ-041 Withdrawal and abort: request dropped in WAIT_HLDA -> HRQ=0 next edge; HLDA dropped in GRANT -> IDLE, DACK inactive; nReset pulsed in GRANT -> all outputs at reset values.

Source files
------------

// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter
//   Four-channel DMA request arbiter with a hold-request handshake to the CPU.
//   It collects hardware (DREQ) and software (ReqReg) requests and asks the CPU
//   for the bus (HRQ). Once HLDA arrives it grants one channel (DACK / GrantChan)
//   until the timing engine reports end of service (SvcDone). Priority is either
//   fixed (channel 0 highest) or rotating (last serviced channel becomes lowest).
//
// Ports
//   Clock        system clock, rising edge
//   nReset       asynchronous active-low reset
//   MasterClear  synchronous clear, same effect as reset
//   DREQ[3:0]    hardware requests, active level selected by CmdReg[6]
//   ReqReg[3:0]  software requests, active-high, not maskable
//   MaskReg[3:0] per-channel mask for hardware requests (1 = masked)
//   CmdReg[7:0]  bit2 disable, bit4 rotating priority, bit6 DREQ active-low,
//                bit7 DACK active-high
//   HLDA         hold acknowledge from the CPU
//   SvcDone      one-cycle end-of-service pulse
//   HRQ          hold request to the CPU (registered)
//   DACK[3:0]    per-channel acknowledge, active level selected by CmdReg[7]
//   GrantValid   a channel currently owns the bus
//   GrantChan    index of the granted channel
//   ReqStatus    registered effective request vector
module dma_priority_arbiter #(
  parameter int REQ_SYNC = 1
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       MasterClear,
  input  logic [3:0] DREQ,
  input  logic [3:0] ReqReg,
  input  logic [3:0] MaskReg,
  input  logic [7:0] CmdReg,
  input  logic       HLDA,
  input  logic       SvcDone,
  output logic       HRQ,
  output logic [3:0] DACK,
  output logic       GrantValid,
  output logic [1:0] GrantChan,
  output logic [3:0] ReqStatus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HLDA = 2'd1,
    GRANT     = 2'd2,
    RELEASE   = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic       hrq_reg, hrq_next;
  logic       gv_reg, gv_next;
  logic [1:0] gchan_reg, gchan_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [3:0] status_reg;

  logic [3:0] dreq_s;
  logic [3:0] eff_req;
  logic [1:0] base;
  logic [3:0] rot_req;
  logic [1:0] winner;
  logic [3:0] grant_onehot;

  // Command bits this block does not use.
  logic unused_cmd;
  assign unused_cmd = ^{CmdReg[5], CmdReg[3], CmdReg[1:0]};

  // Optional input register stage on the raw DREQ pins.
  generate
    if (REQ_SYNC != 0) begin : g_sync
      logic [3:0] dreq_sync_reg;
      always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)          dreq_sync_reg <= '0;
        else if (MasterClear) dreq_sync_reg <= '0;
        else                  dreq_sync_reg <= DREQ;
      end
      assign dreq_s = dreq_sync_reg;
    end else begin : g_nosync
      assign dreq_s = DREQ;
    end
  endgenerate

  // Software requests bypass the mask.
  assign eff_req = ((dreq_s ^ {4{CmdReg[6]}}) & ~MaskReg) | ReqReg;

  // Rotate the request vector so that index 0 is the current top priority;
  // fixed mode is simply rotation by zero.
  assign base = CmdReg[4] ? ptr_reg : 2'd0;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign rot_req[gi] = eff_req[2'(base + 2'(gi))];
    end
  endgenerate

  always_comb begin
    winner = base;
    if (rot_req[0])      winner = base;
    else if (rot_req[1]) winner = base + 2'd1;
    else if (rot_req[2]) winner = base + 2'd2;
    else if (rot_req[3]) winner = base + 2'd3;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_reg  <= IDLE;
      hrq_reg    <= 1'b0;
      gv_reg     <= 1'b0;
      gchan_reg  <= 2'd0;
      ptr_reg    <= 2'd0;
      status_reg <= 4'd0;
    end else if (MasterClear) begin
      state_reg  <= IDLE;
      hrq_reg    <= 1'b0;
      gv_reg     <= 1'b0;
      gchan_reg  <= 2'd0;
      ptr_reg    <= 2'd0;
      status_reg <= 4'd0;
    end else begin
      state_reg  <= state_next;
      hrq_reg    <= hrq_next;
      gv_reg     <= gv_next;
      gchan_reg  <= gchan_next;
      ptr_reg    <= ptr_next;
      status_reg <= eff_req;
    end
  end

  always_comb begin
    state_next = state_reg;
    hrq_next   = hrq_reg;
    gv_next    = gv_reg;
    gchan_next = gchan_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if ((|eff_req) && !CmdReg[2]) begin
          state_next = WAIT_HLDA;
          hrq_next   = 1'b1;
        end
      end
      WAIT_HLDA: begin
        // Withdrawal wins over a simultaneous HLDA: nothing left to grant.
        if (eff_req == 4'd0) begin
          state_next = IDLE;
          hrq_next   = 1'b0;
        end else if (HLDA) begin
          state_next = GRANT;
          gv_next    = 1'b1;
          gchan_next = winner;
        end
      end
      GRANT: begin
        // Losing HLDA mid-service aborts without advancing the rotation.
        if (!HLDA) begin
          state_next = IDLE;
          hrq_next   = 1'b0;
          gv_next    = 1'b0;
        end else if (SvcDone) begin
          state_next = RELEASE;
          hrq_next   = 1'b0;
          gv_next    = 1'b0;
          if (CmdReg[4]) ptr_next = gchan_reg + 2'd1;
        end
      end
      RELEASE: begin
        if (!HLDA) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        hrq_next   = 1'b0;
        gv_next    = 1'b0;
      end
    endcase
  end

  // Acknowledge is decoded from registered grant state, so an asynchronous
  // reset removes it immediately; polarity follows CmdReg[7] live.
  assign grant_onehot = gv_reg ? (4'b0001 << gchan_reg) : 4'b0000;
  assign DACK         = grant_onehot ^ {4{~CmdReg[7]}};

  assign HRQ        = hrq_reg;
  assign GrantValid = gv_reg;
  assign GrantChan  = gchan_reg;
  assign ReqStatus  = status_reg;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Randomized and directed bench for dma_priority_arbiter with a
// transaction-level reference model of the arbitration rules.
module tb_dma_priority_arbiter;

  logic       Clock = 1'b0;
  logic       nReset = 1'b0;
  logic       MasterClear = 1'b0;
  logic [3:0] DREQ = 4'd0;
  logic [3:0] ReqReg = 4'd0;
  logic [3:0] MaskReg = 4'd0;
  logic [7:0] CmdReg = 8'd0;
  logic       HLDA = 1'b0;
  logic       SvcDone = 1'b0;
  logic       HRQ;
  logic [3:0] DACK;
  logic       GrantValid;
  logic [1:0] GrantChan;
  logic [3:0] ReqStatus;

  int checks = 0;
  int errors = 0;

  dma_priority_arbiter dut (
    .Clock(Clock), .nReset(nReset), .MasterClear(MasterClear),
    .DREQ(DREQ), .ReqReg(ReqReg), .MaskReg(MaskReg), .CmdReg(CmdReg),
    .HLDA(HLDA), .SvcDone(SvcDone), .HRQ(HRQ), .DACK(DACK),
    .GrantValid(GrantValid), .GrantChan(GrantChan), .ReqStatus(ReqStatus)
  );

  always #5 Clock = ~Clock;

  // Reference model: who owns the bus, whether the hold is requested,
  // whether we are waiting for the CPU to take HLDA back, rotation pointer.
  logic [3:0] m_sync;
  int         m_owner;
  bit         m_hrq;
  bit         m_rel;
  int         m_ptr;
  int         m_gchan;
  logic [3:0] m_status;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sync = 4'd0; m_owner = -1; m_hrq = 0; m_rel = 0;
    m_ptr = 0; m_gchan = 0; m_status = 4'd0;
  endtask

  function automatic int pick(input logic [3:0] eff, input bit rot, input int ptr);
    int start = rot ? ptr : 0;
    for (int k = 0; k < 4; k++) begin
      int c = (start + k) % 4;
      if (eff[c]) return c;
    end
    return 0;
  endfunction

  task automatic model_step();
    logic [3:0] eff;
    eff = ((m_sync ^ {4{CmdReg[6]}}) & ~MaskReg) | ReqReg;
    if (!nReset || MasterClear) begin
      model_reset();
      return;
    end
    if (m_owner >= 0) begin
      if (!HLDA) begin
        m_owner = -1; m_hrq = 0;
      end else if (SvcDone) begin
        if (CmdReg[4]) m_ptr = (m_owner + 1) % 4;
        m_owner = -1; m_hrq = 0; m_rel = 1;
      end
    end else if (m_rel) begin
      if (!HLDA) m_rel = 0;
    end else if (m_hrq) begin
      if (eff == 4'd0) m_hrq = 0;
      else if (HLDA) begin
        m_owner = pick(eff, CmdReg[4], m_ptr);
        m_gchan = m_owner;
        $display("grant ch=%0d req=%b rot=%0d t=%0t", m_owner, eff, CmdReg[4], $time);
      end
    end else if (eff != 4'd0 && !CmdReg[2]) begin
      m_hrq = 1;
    end
    m_status = eff;
    m_sync = DREQ;
  endtask

  task automatic compare_all();
    logic [3:0] oh;
    logic [3:0] exp_dack;
    oh = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
    exp_dack = CmdReg[7] ? oh : ~oh;
    check("hrq", 8'(HRQ), 8'(m_hrq));
    check("grant_valid", 8'(GrantValid), 8'(m_owner >= 0));
    check("dack", 8'(DACK), 8'(exp_dack));
    check("req_status", 8'(ReqStatus), 8'(m_status));
    if (m_owner >= 0) check("grant_chan", 8'(GrantChan), 8'(m_gchan));
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge Clock);
    model_step();
    @(negedge Clock);
    compare_all();
  endtask

  task automatic quiesce();
    DREQ = 4'd0; ReqReg = 4'd0; MaskReg = 4'd0; SvcDone = 0; HLDA = 0;
    MasterClear = 1;
    tick();
    MasterClear = 0;
  endtask

  // Wait for HRQ, hold HLDA off for 'delay' cycles, then grant.
  task automatic get_grant(input int delay, output int ch);
    int n = 0;
    HLDA = 0;
    while (!HRQ && n < 20) begin tick(); n++; end
    check("hrq_timeout", 8'(HRQ), 8'd1);
    repeat (delay) tick();
    HLDA = 1;
    n = 0;
    do begin tick(); n++; end while (!GrantValid && n < 5);
    check("grant_timeout", 8'(GrantValid), 8'd1);
    ch = int'(GrantChan);
  endtask

  task automatic finish_grant();
    SvcDone = 1;
    tick();
    SvcDone = 0;
    check("release_gv", 8'(GrantValid), 8'd0);
    check("release_hrq", 8'(HRQ), 8'd0);
    tick();
    HLDA = 0;
    tick();
  endtask

  initial begin
    int ch;
    int rot_exp[5] = '{0, 1, 2, 3, 0};

    // Reset state
    model_reset();
    @(negedge Clock);
    check("rst_hrq", 8'(HRQ), 8'd0);
    check("rst_gv", 8'(GrantValid), 8'd0);
    check("rst_dack", 8'(DACK), 8'hF);
    check("rst_status", 8'(ReqStatus), 8'd0);
    tick();
    nReset = 1;
    repeat (3) tick();
    check("idle_dack", 8'(DACK), 8'hF);

    // Fixed priority
    DREQ = 4'b0110;
    get_grant(3, ch);
    check("fixed_ch", 8'(ch), 8'd1);
    check("fixed_dack", 8'(DACK), 8'b1101);
    DREQ = 4'b0100;
    finish_grant();
    get_grant(0, ch);
    check("fixed_ch2", 8'(ch), 8'd2);
    DREQ = 4'd0;
    finish_grant();

    // Rotating priority
    CmdReg = 8'h10;
    quiesce();
    DREQ = 4'hF;
    for (int i = 0; i < 5; i++) begin
      get_grant(0, ch);
      check("rot_ch", 8'(ch), 8'(rot_exp[i]));
      finish_grant();
    end

    // Mask and software request
    CmdReg = 8'h00;
    quiesce();
    MaskReg = 4'hF; DREQ = 4'hF;
    repeat (5) tick();
    check("mask_hrq", 8'(HRQ), 8'd0);
    check("mask_status", 8'(ReqStatus), 8'd0);
    ReqReg = 4'b0100;
    get_grant(1, ch);
    check("sw_ch", 8'(ch), 8'd2);
    ReqReg = 4'd0;
    finish_grant();

    // Polarity and disable
    CmdReg = 8'hC0;
    quiesce();
    DREQ = 4'b1110;
    get_grant(0, ch);
    check("pol_ch", 8'(ch), 8'd0);
    check("pol_dack", 8'(DACK), 8'b0001);
    SvcDone = 1; tick(); SvcDone = 0;
    CmdReg = 8'hC4;
    HLDA = 0;
    repeat (5) tick();
    check("disable_hrq", 8'(HRQ), 8'd0);

    // Withdrawal in WAIT_HLDA
    CmdReg = 8'h00;
    quiesce();
    DREQ = 4'b0001;
    repeat (3) tick();
    check("wd_hrq_up", 8'(HRQ), 8'd1);
    DREQ = 4'd0;
    repeat (2) tick();
    check("wd_hrq_down", 8'(HRQ), 8'd0);

    // HLDA dropped during GRANT
    DREQ = 4'b1000;
    get_grant(0, ch);
    HLDA = 0;
    tick();
    check("abort_gv", 8'(GrantValid), 8'd0);
    check("abort_dack", 8'(DACK), 8'hF);
    check("abort_hrq", 8'(HRQ), 8'd0);

    // Asynchronous reset during GRANT
    get_grant(0, ch);
    nReset = 0;
    #1;
    model_reset();
    check("areset_hrq", 8'(HRQ), 8'd0);
    check("areset_gv", 8'(GrantValid), 8'd0);
    check("areset_dack", 8'(DACK), 8'hF);
    check("areset_chan", 8'(GrantChan), 8'd0);
    check("areset_status", 8'(ReqStatus), 8'd0);
    tick();
    nReset = 1;
    DREQ = 4'd0; HLDA = 0;
    tick();

    // Randomized traffic with a well-behaved (mostly) CPU
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 150 == 0)
        CmdReg = {1'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'b0,
                  1'($urandom_range(0, 7) == 0), 2'b00};
      if ($urandom_range(0, 3) == 0) DREQ = 4'($urandom);
      if ($urandom_range(0, 15) == 0) ReqReg = 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 15) == 0) MaskReg = 4'($urandom);
      if (m_hrq && !HLDA && $urandom_range(0, 2) == 0) HLDA = 1;
      else if (!m_hrq && HLDA && m_owner < 0 && $urandom_range(0, 1) == 0) HLDA = 0;
      else if (m_owner >= 0 && $urandom_range(0, 39) == 0) HLDA = 0;
      SvcDone = ($urandom_range(0, 4) == 0);
      MasterClear = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
